reorder_buf: RTL and testbench

REORDER_BUF -- requirements
Module: reorder_buf

---
 rtl/reorder_buf_pkg.sv | 33 +++
 rtl/reorder_buf.sv | 124 ++++++++++++
 tb/tb_reorder_buf.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buf_pkg.sv
// Shared RV32I types for the reorder buffer: the ROB entry record and the
// opcodes whose rd field is not a destination register.
package rv32i_types;

    // Tag fields are stored at a fixed maximum width; the ROB zero-extends its TAG_W tags into them.
    localparam int ROB_TAG_MAX_W = 8;

    localparam logic [6:0] op_b_store = 7'b0100011;
    localparam logic [6:0] op_b_br    = 7'b1100011;

    typedef struct packed {
        logic [31:0]              inst;
        logic [31:0]              pc;
        logic [ROB_TAG_MAX_W-1:0] tag;
        logic [ROB_TAG_MAX_W-1:0] rs1_tag;
        logic [ROB_TAG_MAX_W-1:0] rs2_tag;
        logic [31:0]              rs1_rdata;
        logic [31:0]              rs2_rdata;
        logic [31:0]              wdata;
        logic                     valid;
        logic                     ready;
        logic                     redirect;
        logic [31:0]              target;
    } rob_entry_t;

    function automatic logic [4:0] rd_of(input logic [31:0] inst);
        if (inst[6:0] == op_b_store || inst[6:0] == op_b_br) begin
            return 5'd0;
        end
        return inst[11:7];
    endfunction

endpackage

// File: rtl/reorder_buf.sv
// In-order-retire reorder buffer: allocates tagged entries at dispatch, accepts
// out-of-order CDB writebacks, retires one ready head per cycle, and flushes on redirect.
module reorder_buf
    import rv32i_types::*;
#(
    parameter int TAG_W = 5,
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             disp_valid,
    output logic             disp_ready,
    input  logic [31:0]      disp_inst,
    input  logic [31:0]      disp_pc,
    output logic [TAG_W-1:0] disp_tag,

    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_wdata,
    input  logic [31:0]      cdb_rs1_rdata,
    input  logic [31:0]      cdb_rs2_rdata,
    input  logic             cdb_redirect,
    input  logic [31:0]      cdb_target,

    output logic             commit_valid,
    output logic [TAG_W-1:0] commit_tag,
    output logic [4:0]       commit_rd_addr,
    output logic [31:0]      commit_wdata,

    output logic             flush,
    output logic [31:0]      pc_new
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    rob_entry_t       rob_entries [DEPTH];
    logic [PTR_W:0]   rptr;
    logic [PTR_W:0]   wptr;
    logic [PTR_W:0]   count;

    rob_entry_t       head;
    rob_entry_t       cdb_entry;
    rob_entry_t       disp_entry;
    logic             disp_fire;
    logic             cdb_hit;
    logic [PTR_W-1:0] ridx;
    logic [PTR_W-1:0] widx;
    logic [PTR_W-1:0] cidx;

    assign ridx = rptr[PTR_W-1:0];
    assign widx = wptr[PTR_W-1:0];
    assign cidx = cdb_tag[PTR_W-1:0];

    assign head      = rob_entries[ridx];
    assign cdb_entry = rob_entries[cidx];

    assign disp_ready = (count != FULL_COUNT);
    assign disp_tag   = TAG_W'(wptr);

    assign commit_valid   = head.valid && head.ready;
    assign commit_tag     = TAG_W'(rptr);
    assign commit_rd_addr = rd_of(head.inst);
    assign commit_wdata   = head.wdata;

    assign flush  = commit_valid && head.redirect;
    assign pc_new = flush ? head.target : 32'h0;

    assign disp_fire = disp_valid && disp_ready && !flush;
    // Stale writebacks (entry reused under a newer wrap) fail the stored-tag compare.
    assign cdb_hit   = cdb_valid && !flush && cdb_entry.valid &&
                       (cdb_entry.tag == ROB_TAG_MAX_W'(cdb_tag));

    always_comb begin
        disp_entry       = '0;
        disp_entry.inst  = disp_inst;
        disp_entry.pc    = disp_pc;
        disp_entry.tag   = ROB_TAG_MAX_W'(wptr);
        disp_entry.valid = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                rob_entries[i] <= '0;
            end
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                rob_entries[i].valid <= 1'b0;
                rob_entries[i].ready <= 1'b0;
            end
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (disp_fire) begin
                rob_entries[widx] <= disp_entry;
                wptr              <= wptr + 1'b1;
            end
            if (cdb_hit) begin
                rob_entries[cidx].wdata     <= cdb_wdata;
                rob_entries[cidx].rs1_rdata <= cdb_rs1_rdata;
                rob_entries[cidx].rs2_rdata <= cdb_rs2_rdata;
                rob_entries[cidx].redirect  <= cdb_redirect;
                rob_entries[cidx].target    <= cdb_target;
                rob_entries[cidx].ready     <= 1'b1;
            end
            if (commit_valid) begin
                rob_entries[ridx].valid <= 1'b0;
                rptr                    <= rptr + 1'b1;
            end
            case ({disp_fire, commit_valid})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_reorder_buf.sv
// Directed scoreboard bench for reorder_buf: dispatch pushes expected commits,
// commits pop and compare; pointers/count/entries are probed hierarchically.
module tb_reorder_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        disp_valid;
    logic        disp_ready;
    logic [31:0] disp_inst;
    logic [31:0] disp_pc;
    logic [4:0]  disp_tag;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_wdata;
    logic [31:0] cdb_rs1_rdata;
    logic [31:0] cdb_rs2_rdata;
    logic        cdb_redirect;
    logic [31:0] cdb_target;
    logic        commit_valid;
    logic [4:0]  commit_tag;
    logic [4:0]  commit_rd_addr;
    logic [31:0] commit_wdata;
    logic        flush;
    logic [31:0] pc_new;

    reorder_buf dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_inst(disp_inst),
        .disp_pc(disp_pc), .disp_tag(disp_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_wdata(cdb_wdata),
        .cdb_rs1_rdata(cdb_rs1_rdata), .cdb_rs2_rdata(cdb_rs2_rdata),
        .cdb_redirect(cdb_redirect), .cdb_target(cdb_target),
        .commit_valid(commit_valid), .commit_tag(commit_tag),
        .commit_rd_addr(commit_rd_addr), .commit_wdata(commit_wdata),
        .flush(flush), .pc_new(pc_new)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] tag;
        logic [4:0] rd;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    exp_t        sbq[$];
    logic [31:0] model_wdata [16];
    logic [4:0]  exp_wptr;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_inst(input int i);
        logic [6:0] op;
        case (i % 4)
            1:       op = 7'b0100011;
            2:       op = 7'b1100011;
            default: op = 7'b0110011;
        endcase
        return {12'hABC, 8'(i), 5'(i * 3 + 1), op};
    endfunction

    function automatic logic [4:0] exp_rd(input logic [31:0] inst);
        if (inst[6:0] == 7'b0100011 || inst[6:0] == 7'b1100011) return 5'd0;
        return inst[11:7];
    endfunction

    // Compares any commit visible in the current cycle, then advances one clock.
    task automatic tick();
        exp_t e;
        if (commit_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                check("commit_unexpected", {31'b0, commit_valid}, 32'd0);
            end else begin
                e = sbq.pop_front();
                check("commit_tag", commit_tag, e.tag);
                check("commit_rd", commit_rd_addr, e.rd);
                check("commit_wdata", commit_wdata, model_wdata[e.tag[3:0]]);
            end
            if (flush === 1'b1) sbq.delete();
        end
        @(posedge clk);
        #1;
        disp_valid   = 1'b0;
        cdb_valid    = 1'b0;
        cdb_redirect = 1'b0;
    endtask

    task automatic dispatch(input int i);
        check("disp_ready", disp_ready, 1);
        check("disp_tag", disp_tag, exp_wptr);
        disp_valid = 1'b1;
        disp_inst  = mk_inst(i);
        disp_pc    = 32'h1000 + 32'(4 * i);
        sbq.push_back('{exp_wptr, exp_rd(mk_inst(i))});
        exp_wptr++;
        tick();
    endtask

    task automatic cdb(input logic [4:0] tag, input logic [31:0] wd, input logic redir,
                       input logic [31:0] tgt, input bit legit);
        cdb_valid     = 1'b1;
        cdb_tag       = tag;
        cdb_wdata     = wd;
        cdb_rs1_rdata = ~wd;
        cdb_rs2_rdata = wd ^ 32'h5555_5555;
        cdb_redirect  = redir;
        cdb_target    = tgt;
        if (legit) model_wdata[tag[3:0]] = wd;
        tick();
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        check("drain_left", sbq.size(), 0);
        check("drain_count", dut.count, 0);
    endtask

    initial begin
        rst = 1'b1;
        disp_valid = 1'b0; disp_inst = '0; disp_pc = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_wdata = '0; cdb_rs1_rdata = '0;
        cdb_rs2_rdata = '0; cdb_redirect = 1'b0; cdb_target = '0;
        exp_wptr = '0;
        for (int i = 0; i < 16; i++) model_wdata[i] = '0;
        #1;
        check("rst_disp_ready", disp_ready, 1);
        check("rst_commit_valid", commit_valid, 0);
        check("rst_flush", flush, 0);
        check("rst_pc_new", pc_new, 0);
        check("rst_count", dut.count, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #10;

        // Out-of-order writeback, in-order retire
        dispatch(0); dispatch(1); dispatch(2);
        cdb(5'd2, 32'h22, 1'b0, 32'h0, 1'b1);
        check("ooo_no_commit_a", commit_valid, 0);
        cdb(5'd1, 32'h11, 1'b0, 32'h0, 1'b1);
        check("ooo_no_commit_b", commit_valid, 0);
        cdb(5'd0, 32'hAA, 1'b0, 32'h0, 1'b1);
        check("ooo_cv0", commit_valid, 1);
        check("ooo_tag0", commit_tag, 0);
        check("ooo_wdata0", commit_wdata, 32'hAA);
        tick();
        check("ooo_cv1", commit_valid, 1);
        check("ooo_tag1", commit_tag, 1);
        tick();
        check("ooo_cv2", commit_valid, 1);
        check("ooo_tag2", commit_tag, 2);
        tick();
        check("ooo_idle", commit_valid, 0);

        // Redirect at head flushes; same-cycle dispatch is dropped
        dispatch(3); dispatch(4);
        cdb(5'd3, 32'h33, 1'b1, 32'h6000_0040, 1'b1);
        check("redir_cv", commit_valid, 1);
        check("redir_flush", flush, 1);
        check("redir_pc_new", pc_new, 32'h6000_0040);
        disp_valid = 1'b1;
        disp_inst  = mk_inst(77);
        tick();
        exp_wptr = '0;
        check("redir_count", dut.count, 0);
        check("redir_rptr", dut.rptr, 0);
        check("redir_wptr", dut.wptr, 0);
        check("redir_e4_valid", dut.rob_entries[4].valid, 0);
        check("redir_e5_valid", dut.rob_entries[5].valid, 0);
        check("redir_flush_low", flush, 0);
        check("redir_pc_new_low", pc_new, 0);

        // Fill to full, then refuse the 17th
        for (int i = 0; i < 16; i++) dispatch(10 + i);
        check("full_ready", disp_ready, 0);
        check("full_count", dut.count, 16);
        check("full_wptr", dut.wptr, 5'h10);
        disp_valid = 1'b1;
        disp_inst  = mk_inst(99);
        tick();
        check("full_count_hold", dut.count, 16);
        check("full_wptr_hold", dut.wptr, 5'h10);
        check("full_e0_inst", dut.rob_entries[0].inst, mk_inst(10));
        for (int i = 0; i < 16; i++) cdb(5'(i), 32'h100 + 32'(i), 1'b0, 32'h0, 1'b1);
        drain();
        check("wrap_rptr", dut.rptr, 5'h10);

        // Stale tag after wrap
        for (int i = 0; i < 4; i++) dispatch(30 + i);
        cdb(5'h03, 32'hDEAD, 1'b0, 32'h0, 1'b0);
        check("stale_ready", dut.rob_entries[3].ready, 0);
        check("stale_tag", dut.rob_entries[3].tag, 8'h13);
        check("stale_no_commit", commit_valid, 0);
        for (int i = 0; i < 4; i++) cdb(5'h10 + 5'(i), 32'h200 + 32'(i), 1'b0, 32'h0, 1'b1);
        drain();

        // Simultaneous dispatch and commit at count 5
        for (int i = 0; i < 5; i++) dispatch(40 + i);
        cdb(5'h14, 32'h314, 1'b0, 32'h0, 1'b1);
        check("sim_cv", commit_valid, 1);
        check("sim_count_pre", dut.count, 5);
        dispatch(45);
        check("sim_count", dut.count, 5);
        check("sim_rptr", dut.rptr, 5'h15);
        check("sim_wptr", dut.wptr, 5'h1A);

        // Async reset mid-stream with 7 in flight
        dispatch(46); dispatch(47);
        check("pre_rst_count", dut.count, 7);
        #2;
        rst = 1'b1;
        #1;
        check("arst_count", dut.count, 0);
        check("arst_cv", commit_valid, 0);
        check("arst_rptr", dut.rptr, 0);
        check("arst_ready", disp_ready, 1);
        @(posedge clk); #1;
        check("arst_cv_hold", commit_valid, 0);
        rst = 1'b0;
        sbq.delete();
        exp_wptr = '0;
        tick();
        check("post_rst_count", dut.count, 0);
        check("post_rst_cv", commit_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
